// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, per-pixel flag bundle and timing helper functions.
package vga_timing_pkg;

  // 640x480 @ 60 Hz defaults
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_PULSE = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_DATA  = 640;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_PULSE = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_DATA  = 480;
  localparam int DEF_LEAD    = 2;
  localparam int MAX_LEAD    = 8;

  // Raw per-position timing flags, delayed as one word so they stay aligned
  typedef struct packed {
    logic hSync;
    logic vSync;
    logic active;
    logic vActive;
    logic frameStart;
  } timingFlags_t;

  function automatic int hTotal(int front, int pulse, int back, int data);
    return front + pulse + back + data;
  endfunction

  function automatic int vTotal(int front, int pulse, int back, int data);
    return front + pulse + back + data;
  endfunction

  // Active region starts after front porch, sync and back porch
  function automatic int hStart(int front, int pulse, int back);
    return front + pulse + back;
  endfunction

  function automatic int vStart(int front, int pulse, int back);
    return front + pulse + back;
  endfunction

  // Bits needed to count 0..n-1, never less than one
  function automatic int widthOf(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// Enable-gated shift register used to align timing flags with the pixel output.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one position per enabled edge; everything clears on reset
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (iEn) begin
      stage[0] <= iD;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign oQ = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters, early data request with pixel
// coordinates, and sync/valid/colour outputs delayed LEAD enabled cycles behind
// the request so a pipelined pixel source can answer in time.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_FRONT = DEF_H_FRONT,
  parameter int   H_PULSE = DEF_H_PULSE,
  parameter int   H_BACK  = DEF_H_BACK,
  parameter int   H_DATA  = DEF_H_DATA,
  parameter int   V_FRONT = DEF_V_FRONT,
  parameter int   V_PULSE = DEF_V_PULSE,
  parameter int   V_BACK  = DEF_V_BACK,
  parameter int   V_DATA  = DEF_V_DATA,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   LEAD    = DEF_LEAD,
  parameter int   COLOR_W = 8,
  localparam int  XW      = widthOf(H_DATA),
  localparam int  YW      = widthOf(V_DATA)
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iEn,
  input  logic [COLOR_W-1:0] iR,
  input  logic [COLOR_W-1:0] iG,
  input  logic [COLOR_W-1:0] iB,
  output logic [COLOR_W-1:0] oR,
  output logic [COLOR_W-1:0] oG,
  output logic [COLOR_W-1:0] oB,
  output logic               oHSync,
  output logic               oVSync,
  output logic               oDataValid,
  output logic               oLineValid,
  output logic               oDataRequest,
  output logic [XW-1:0]      oX,
  output logic [YW-1:0]      oY,
  output logic               oFrameStart
);

  localparam int H_TOTAL = hTotal(H_FRONT, H_PULSE, H_BACK, H_DATA);
  localparam int V_TOTAL = vTotal(V_FRONT, V_PULSE, V_BACK, V_DATA);
  localparam int HCW     = widthOf(H_TOTAL);
  localparam int VCW     = widthOf(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST       = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_SYNC_BEGIN = HCW'(H_FRONT);
  localparam logic [HCW-1:0] H_SYNC_END   = HCW'(H_FRONT + H_PULSE);
  localparam logic [HCW-1:0] H_ACT        = HCW'(hStart(H_FRONT, H_PULSE, H_BACK));
  localparam logic [VCW-1:0] V_LAST       = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_SYNC_BEGIN = VCW'(V_FRONT);
  localparam logic [VCW-1:0] V_SYNC_END   = VCW'(V_FRONT + V_PULSE);
  localparam logic [VCW-1:0] V_ACT        = VCW'(vStart(V_FRONT, V_PULSE, V_BACK));

  // Request lead outside its supported range is a configuration error
  if (LEAD < 1 || LEAD > MAX_LEAD) begin : gLeadCheck
    $error("vga_timing_gen: LEAD out of range 1..8");
  end

  logic [HCW-1:0] hc;
  logic [VCW-1:0] vc;
  logic           hActive;
  logic           vActive;
  timingFlags_t   rawFlags;
  timingFlags_t   delayedFlags;

  // Pixel and line counters; the line counter steps on the pixel wrap edge
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      hc <= '0;
      vc <= '0;
    end else if (iEn) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Decode region flags for the current counter position (front, sync, back, active)
  always_comb begin
    hActive             = (hc >= H_ACT);
    vActive             = (vc >= V_ACT);
    rawFlags.hSync      = (hc >= H_SYNC_BEGIN) && (hc < H_SYNC_END);
    rawFlags.vSync      = (vc >= V_SYNC_BEGIN) && (vc < V_SYNC_END);
    rawFlags.active     = hActive && vActive;
    rawFlags.vActive    = vActive;
    rawFlags.frameStart = (hc == '0) && (vc == '0);
  end

  // Early request with coordinates; coordinates hold outside the active area
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oDataRequest <= 1'b0;
      oX           <= '0;
      oY           <= '0;
    end else if (iEn) begin
      oDataRequest <= rawFlags.active;
      if (rawFlags.active) begin
        oX <= XW'(hc - H_ACT);
        oY <= YW'(vc - V_ACT);
      end
    end
  end

  // LEAD stages here plus the output register below trail the request by LEAD
  vga_delay_line #(
    .WIDTH($bits(timingFlags_t)),
    .DEPTH(LEAD)
  ) uFlagDelay (
    .iClk (iClk),
    .iRst (iRst),
    .iEn  (iEn),
    .iD   (rawFlags),
    .oQ   (delayedFlags)
  );

  // Output stage: sync polarity, valid flags and colour gated by delayed active
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oHSync      <= ~HS_POL;
      oVSync      <= ~VS_POL;
      oDataValid  <= 1'b0;
      oLineValid  <= 1'b0;
      oFrameStart <= 1'b0;
      oR          <= '0;
      oG          <= '0;
      oB          <= '0;
    end else if (iEn) begin
      oHSync      <= delayedFlags.hSync ? HS_POL : ~HS_POL;
      oVSync      <= delayedFlags.vSync ? VS_POL : ~VS_POL;
      oDataValid  <= delayedFlags.active;
      oLineValid  <= delayedFlags.vActive;
      oFrameStart <= delayedFlags.frameStart;
      oR          <= delayedFlags.active ? iR : '0;
      oG          <= delayedFlags.active ? iG : '0;
      oB          <= delayedFlags.active ? iB : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 15x7 raster: cycle model of the control
// outputs plus a colour scoreboard fed from the request side.
module tb_vga_timing_gen;

  localparam int HF = 2, HP = 3, HB = 2, HD = 8;
  localparam int VF = 1, VP = 1, VB = 1, VD = 4;
  localparam int HT = 15, VT = 7, FT = 105, HS = 7, VS = 3;
  localparam int LEAD = 2, CW = 8;

  logic iClk = 1'b0;
  logic iRst, iEn;
  logic [CW-1:0] iR, iG, iB;

  logic [CW-1:0] oR, oG, oB, oRP, oGP, oBP;
  logic oHSync, oVSync, oDataValid, oLineValid, oDataRequest, oFrameStart;
  logic oHSyncP, oVSyncP, oDataValidP, oLineValidP, oDataRequestP, oFrameStartP;
  logic [2:0] oX, oXP;
  logic [1:0] oY, oYP;

  vga_timing_gen #(
    .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB), .H_DATA(HD),
    .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB), .V_DATA(VD),
    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(LEAD), .COLOR_W(CW)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iR(iR), .iG(iG), .iB(iB),
    .oR(oR), .oG(oG), .oB(oB), .oHSync(oHSync), .oVSync(oVSync),
    .oDataValid(oDataValid), .oLineValid(oLineValid), .oDataRequest(oDataRequest),
    .oX(oX), .oY(oY), .oFrameStart(oFrameStart)
  );

  vga_timing_gen #(
    .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB), .H_DATA(HD),
    .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB), .V_DATA(VD),
    .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(LEAD), .COLOR_W(CW)
  ) dutPol (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iR(iR), .iG(iG), .iB(iB),
    .oR(oRP), .oG(oGP), .oB(oBP), .oHSync(oHSyncP), .oVSync(oVSyncP),
    .oDataValid(oDataValidP), .oLineValid(oLineValidP), .oDataRequest(oDataRequestP),
    .oX(oXP), .oY(oYP), .oFrameStart(oFrameStartP)
  );

  always #5 iClk = ~iClk;

  int errCount = 0;
  int checkCount = 0;
  int k;
  logic [2:0] expX;
  logic [1:0] expY;
  logic [23:0] expRgb;
  logic [23:0] pending;
  logic [23:0] sb[$];
  int firstReq, firstDv, firstFs;
  logic countOn;
  int hsLow, vsLow, vsHighP, reqCount, runLen;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // {hsync, vsync, active, vactive, framestart} at linear raster position p
  function automatic logic [4:0] rawAt(int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return {h >= HF && h < HF + HP, v >= VF && v < VF + VP,
            h >= HS && v >= VS, v >= VS, h == 0 && v == 0};
  endfunction

  // Expected {req, x, y, hs, vs, dv, lv, fs} after kk enabled edges
  function automatic logic [12:0] ctrlExp(int kk, logic hp, logic vp);
    logic [4:0] f;
    logic req, hs, vs, dv, lv, fs;
    req = 1'b0; hs = ~hp; vs = ~vp; dv = 1'b0; lv = 1'b0; fs = 1'b0;
    if (kk >= 1) begin
      f = rawAt(kk - 1);
      req = f[2];
    end
    if (kk >= LEAD + 1) begin
      f = rawAt(kk - 1 - LEAD);
      hs = f[4] ? hp : ~hp;
      vs = f[3] ? vp : ~vp;
      dv = f[2]; lv = f[1]; fs = f[0];
    end
    return {req, expX, expY, hs, vs, dv, lv, fs};
  endfunction

  function automatic logic [23:0] pattern(logic [2:0] x, logic [1:0] y);
    return {8'(x * 5 + 3), 8'(y * 7 + 1), 8'({5'd0, x} ^ 8'hA5)};
  endfunction

  task automatic checkAll();
    checkVal("ctrl", {19'd0, oDataRequest, oX, oY, oHSync, oVSync, oDataValid, oLineValid, oFrameStart},
             {19'd0, ctrlExp(k, 1'b0, 1'b0)});
    checkVal("ctrlPol", {19'd0, oDataRequestP, oXP, oYP, oHSyncP, oVSyncP, oDataValidP, oLineValidP, oFrameStartP},
             {19'd0, ctrlExp(k, 1'b1, 1'b1)});
    checkVal("rgb", {8'd0, oR, oG, oB}, {8'd0, expRgb});
    checkVal("rgbPol", {8'd0, oRP, oGP, oBP}, {8'd0, expRgb});
  endtask

  task automatic clearModel();
    k = 0; expX = '0; expY = '0; expRgb = '0; pending = '0;
    sb.delete();
    iR = '0; iG = '0; iB = '0;
    runLen = 0;
  endtask

  task automatic stepCycle(input logic en);
    logic [4:0] f;
    iEn = en;
    @(posedge iClk);
    #1;
    if (en) begin
      k++;
      {iR, iG, iB} = pending;
      pending = oDataRequest ? pattern(oX, oY) : 24'hFFFFFF;
      f = rawAt(k - 1);
      if (f[2]) begin
        expX = 3'((k - 1) % HT - HS);
        expY = 2'(((k - 1) / HT) % VT - VS);
        sb.push_back(pattern(expX, expY));
      end
      if (k >= LEAD + 1 && rawAt(k - 1 - LEAD) == rawAt(k - 1 - LEAD) && rawAt(k - 1 - LEAD) >> 2 & 5'd1) begin
        checkVal("sbNonEmpty", 32'(sb.size() > 0), 32'd1);
        expRgb = (sb.size() > 0) ? sb.pop_front() : 24'h0;
      end else begin
        expRgb = '0;
      end
      if (oDataRequest && firstReq < 0) firstReq = k;
      if (oDataValid && firstDv < 0) firstDv = k;
      if (oFrameStart && firstFs < 0) firstFs = k;
      if (countOn) begin
        hsLow += int'(!oHSync);
        vsLow += int'(!oVSync);
        vsHighP += int'(oVSyncP);
        reqCount += int'(oDataRequest);
      end
      if (oDataRequest) runLen++;
      else if (runLen != 0) begin
        checkVal("reqPerLine", 32'(runLen), 32'd8);
        runLen = 0;
      end
    end
    checkAll();
  endtask

  task automatic checkStartup(input string tag);
    checkVal({tag, "FirstReq"}, 32'(firstReq), 32'd53);
    checkVal({tag, "FirstDv"}, 32'(firstDv), 32'd55);
    checkVal({tag, "FirstFs"}, 32'(firstFs), 32'd3);
  endtask

  initial begin
    iRst = 1'b1; iEn = 1'b0; countOn = 1'b0;
    hsLow = 0; vsLow = 0; vsHighP = 0; reqCount = 0;
    clearModel();
    firstReq = -1; firstDv = -1; firstFs = -1;
    repeat (3) begin
      @(posedge iClk);
      #1;
      checkAll();
    end
    iRst = 1'b0;

    // Startup latency and three full frames of counts
    for (int c = 1; c <= 330; c++) begin
      countOn = (c >= 4 && c <= 318);
      stepCycle(1'b1);
    end
    countOn = 1'b0;
    checkStartup("run1");
    checkVal("hsLowCount", 32'(hsLow), 32'd63);
    checkVal("vsLowCount", 32'(vsLow), 32'd45);
    checkVal("vsHighCountPol", 32'(vsHighP), 32'd45);
    checkVal("reqCount", 32'(reqCount), 32'd96);

    // Enable toggling 1,0,0,1: outputs hold across disabled cycles
    for (int c = 0; c < 240; c++) stepCycle((c % 4 == 0) || (c % 4 == 3));

    // Advance to hc=10, vc=4 and reset asynchronously between edges
    for (int c = 0; c < FT && (k % FT) != 70; c++) stepCycle(1'b1);
    checkVal("resetPoint", 32'(k % FT), 32'd70);
    #2;
    iRst = 1'b1;
    #1;
    clearModel();
    checkAll();
    repeat (2) begin
      @(posedge iClk);
      #1;
      checkAll();
    end
    iRst = 1'b0;
    firstReq = -1; firstDv = -1; firstFs = -1;
    for (int c = 1; c <= 70; c++) stepCycle(1'b1);
    checkStartup("run2");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-002 SHALL have parameter H_PULSE, default 96, horizontal sync width in pixels.
REQ-003 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-004 SHALL have parameter H_DATA, default 640, active pixels per line.
REQ-005 SHALL have parameters V_FRONT, V_PULSE, V_BACK, V_DATA, defaults 10, 2, 33, 480; same meaning in lines.
REQ-006 SHALL have parameter HS_POL, default 0, active level of oHSync.
REQ-007 SHALL have parameter VS_POL, default 0, active level of oVSync.
REQ-008 SHALL have parameter LEAD, default 2, range 1..8, cycles between oDataRequest and the matching oDataValid.
REQ-009 SHALL have parameter COLOR_W, default 8, width of each colour channel.
REQ-010 SHALL have ports, in this order: iClk in 1 clock; iRst in 1 asynchronous active-high reset; iEn in 1 pixel enable; iR/iG/iB in COLOR_W pixel colour; oR/oG/oB out COLOR_W gated colour; oHSync out 1; oVSync out 1; oDataValid out 1; oLineValid out 1; oDataRequest out 1; oX out XW requested pixel column; oY out YW requested pixel row; oFrameStart out 1.
REQ-011 XW SHALL be clog2(H_DATA) and YW SHALL be clog2(V_DATA), each with a minimum of 1.

Function
REQ-012 Horizontal counter hc SHALL run 0..H_TOTAL-1 with H_TOTAL = sum of the H parameters; vertical counter vc SHALL run 0..V_TOTAL-1 with V_TOTAL defined the same way.
REQ-013 Counters SHALL advance only on edges with iEn=1; hc SHALL wrap to 0 after H_TOTAL-1, and vc SHALL increment, wrapping to 0 after V_TOTAL-1, on that same edge.
REQ-014 Region order per line SHALL be front, sync, back, active: hsync_raw when H_FRONT <= hc < H_FRONT+H_PULSE; hactive when hc >= H_FRONT+H_PULSE+H_BACK. Vertical SHALL use the same order with the V parameters.
REQ-015 oDataRequest, oX and oY SHALL be registered from the counters with 1 enabled cycle of latency: request = hactive AND vactive; oX = hc - H_START; oY = vc - V_START.
REQ-016 oX and oY SHALL hold their last value while oDataRequest=0.
REQ-017 hsync_raw, vsync_raw, active, vactive and frame-start SHALL pass through a LEAD-deep delay line advancing only on iEn, so that oHSync, oVSync, oDataValid and oLineValid lag oDataRequest by exactly LEAD enabled cycles.
REQ-018 oHSync SHALL equal HS_POL when its delayed raw value is 1, and ~HS_POL otherwise; oVSync SHALL follow the same rule with VS_POL.
REQ-019 On an enabled edge, oR/oG/oB SHALL register iR/iG/iB when the delayed active is 1, and 0 otherwise, so the source presents pixel (oX,oY) LEAD-1 enabled cycles after seeing its request.
REQ-020 oFrameStart SHALL pulse for exactly one enabled cycle, aligned with the output timing, for counter state hc=0, vc=0.
REQ-021 While iEn=0, all registers and outputs SHALL hold their values.

Reset
REQ-022 While iRst=1: hc=vc=0, delay-line contents inactive, oHSync=~HS_POL, oVSync=~VS_POL, oDataValid=oLineValid=oDataRequest=oFrameStart=0, oR/oG/oB=0, oX=oY=0.
REQ-023 Reset assertion mid-frame SHALL take effect immediately, without waiting for a clock edge; after release, timing SHALL restart at hc=vc=0.

Structure
REQ-024 The default timing values and the helper functions for H_TOTAL, V_TOTAL, H_START and V_START SHALL be placed in shared package vga_timing_pkg.
REQ-025 The delay line SHALL be a sub-module vga_delay_line with parameters WIDTH and DEPTH, an enable input and an asynchronous active-high reset to 0.

Verification
Bench parameters: H = 2/3/2/8 (H_TOTAL 15), V = 1/1/1/4 (V_TOTAL 7), LEAD=2, iEn=1 unless stated.
REQ-026 Release reset -> first oDataRequest high after enabled edge 53 with oX=0, oY=0; first oDataValid high after edge 55; oFrameStart high after edge 3.
REQ-027 Run 3 frames -> oHSync low for 3 of every 15 cycles; oVSync low for 15 of every 105 cycles; 8 requests per active line; 32 requests per frame.
REQ-028 Drive iR = oX-dependent pattern with 1-cycle source latency -> each oR equals the value requested LEAD cycles earlier; oR=0 whenever oDataValid=0.
REQ-029 Toggle iEn 1,0,0,1 repeatedly -> sequence of output values identical to the iEn=1 run, each held across disabled cycles.
REQ-030 Assert iRst asynchronously at hc=10, vc=4 -> all outputs take reset values before the next edge; after release, timing matches REQ-026 again.
REQ-031 Set HS_POL=1, VS_POL=1 -> sync polarities inverted; all other outputs unchanged.
